// File: rtl/i_cache.sv
// i_cache: direct-mapped, read-only instruction cache.
// 4 lines x 4 words x 16 bits. tag = addr[15:4], index = addr[3:2], offset = addr[1:0].
// Hits are served combinationally in IDLE. A miss fetches the whole 64-bit block.
// Optional macro ICACHE_STATS_EN adds saturating hit_count / miss_count outputs.
module i_cache (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        c_readM,
  input  logic [15:0] c_address,
  output logic [15:0] c_data,
  output logic        c_ready,
  input  logic        c_flush,
  output logic        m_readM,
  output logic [15:0] m_address,
  input  logic [63:0] m_data,
  input  logic        m_ready
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MISS = 2'd1;
  localparam logic [1:0] FILL = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [3:0]  valid;
  logic [3:0]  valid_nxt;
  logic [13:0] blk_q;
  logic [11:0] tag_mem  [4];
  logic [63:0] data_mem [4];

  logic [1:0]  idx;
  logic [63:0] line;
  logic        hit;
  logic        fill_hit;
  logic        fill_we;
  logic        miss_start;

  assign idx        = c_address[3:2];
  assign line       = data_mem[idx];
  assign hit        = (state == IDLE) && c_readM && valid[idx] &&
                      (tag_mem[idx] == c_address[15:4]);
  // In FILL the matching request necessarily indexes the freshly written line.
  assign fill_hit   = (state == FILL) && c_readM && (c_address[15:2] == blk_q);
  assign fill_we    = (state == MISS) && m_ready;
  assign miss_start = (state == IDLE) && c_readM && !hit;

  // CPU-side response: word select on hit or on the fill-return cycle, else zero.
  always_comb begin
    c_ready = hit || fill_hit;
    c_data  = 16'h0000;
    if (hit || fill_hit) c_data = line[{c_address[1:0], 4'b0000} +: 16];
  end

  // Memory-side request is only ever presented while waiting for a block.
  always_comb begin
    m_readM   = (state == MISS);
    m_address = (state == MISS) ? {blk_q, 2'b00} : 16'h0000;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (miss_start) state_nxt = MISS;
      MISS:    if (m_ready) state_nxt = FILL;
      FILL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Flush clears everything first; an in-flight fill then marks its own line.
  always_comb begin
    valid_nxt = c_flush ? 4'b0000 : valid;
    if (fill_we) valid_nxt[blk_q[1:0]] = 1'b1;
  end

  // Control state, valid bits and the latched block address.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      valid <= 4'b0000;
      blk_q <= 14'd0;
    end else begin
      state <= state_nxt;
      valid <= valid_nxt;
      if (miss_start) blk_q <= c_address[15:2];
    end
  end

  // Tag and data storage; write enable is gated by state, so reset blocks stray fills.
  always_ff @(posedge Clk) begin
    if (fill_we) begin
      tag_mem[blk_q[1:0]]  <= blk_q[13:2];
      data_mem[blk_q[1:0]] <= m_data;
    end
  end

`ifdef ICACHE_STATS_EN
  // Saturating hit / miss statistics.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hit_count  <= 16'd0;
      miss_count <= 16'd0;
    end else begin
      if (hit && (hit_count != 16'hFFFF)) hit_count <= hit_count + 16'd1;
      if (miss_start && (miss_count != 16'hFFFF)) miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_i_cache.sv
// Testbench for i_cache: scoreboard queue of expected fetch words, a separate
// monitor popping on c_ready, a memory responder, and a line-level cache model.
module tb_i_cache;

  logic        Clk;
  logic        Reset;
  logic        c_readM;
  logic [15:0] c_address;
  logic [15:0] c_data;
  logic        c_ready;
  logic        c_flush;
  logic        m_readM;
  logic [15:0] m_address;
  logic [63:0] m_data;
  logic        m_ready;
`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  i_cache dut (
    .Clk(Clk),
    .Reset(Reset),
    .c_readM(c_readM),
    .c_address(c_address),
    .c_data(c_data),
    .c_ready(c_ready),
    .c_flush(c_flush),
    .m_readM(m_readM),
    .m_address(m_address),
    .m_data(m_data),
    .m_ready(m_ready)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [0:1023];
  logic [15:0] exp_q [$];

  // Cache model: which block (addr[15:4]) each index currently holds.
  logic        mv [4];
  logic [11:0] mt [4];
  int          mdl_hits   = 0;
  int          mdl_misses = 0;

  int          resp_delay = 0;
  logic [15:0] exp_blk    = 16'h0000;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] block_of(input logic [15:0] base);
    logic [9:0] b;
    b = base[9:0];
    return {mem[b + 10'd3], mem[b + 10'd2], mem[b + 10'd1], mem[b]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) mv[i] = 1'b0;
  endtask

  // Monitor: every c_ready pops one expected word; otherwise c_data must be zero.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        if (c_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_ready: c_ready=1 c_data=%0h with no request pending", c_data);
          end else begin
            e = exp_q.pop_front();
            check("c_data", {48'd0, c_data}, {48'd0, e});
          end
        end else begin
          check("c_data_when_not_ready", {48'd0, c_data}, 64'd0);
        end
      end
    end
  end

  // Memory responder: checks the block address, waits resp_delay cycles, pulses m_ready.
  initial begin
    logic [15:0] base;
    m_ready = 1'b0;
    m_data  = 64'd0;
    forever begin
      @(negedge Clk);
      if (m_readM && !Reset) begin
        base = m_address;
        check("m_address", {48'd0, m_address}, {48'd0, exp_blk});
        repeat (resp_delay) @(negedge Clk);
        @(posedge Clk);
        #1;
        m_ready = 1'b1;
        m_data  = block_of(base);
        @(posedge Clk);
        #1;
        m_ready = 1'b0;
        m_data  = {$urandom, $urandom};
      end
    end
  end

  // One fetch. mode: 0 plain, 1 flush in the request cycle, 2 flush during the miss.
  // abandon: drop the request once the block read is seen; no response expected.
  // Starts and ends 1 time unit after a rising edge.
  task automatic do_read(input logic [15:0] a, input int mode, input int abandon);
    logic [1:0] ix;
    logic       exp_hit;
    logic       seen;
    logic       fl;
    logic       drop;
    logic       done;
    int         cyc;
    ix      = a[3:2];
    exp_hit = mv[ix] && (mt[ix] == a[15:4]) && (abandon == 0);
    exp_blk = {a[15:2], 2'b00};
    if (abandon == 0) exp_q.push_back(mem[a[9:0]]);
    c_readM   = 1'b1;
    c_address = a;
    c_flush   = (mode == 1);
    cyc  = 0;
    seen = 1'b0;
    drop = 1'b0;
    done = 1'b0;
    while (!done) begin
      fl = 1'b0;
      @(negedge Clk);
      if (c_ready && abandon == 0) begin
        done = 1'b1;
      end else begin
        cyc++;
        if (abandon != 0 && seen && !m_readM) done = 1'b1;
        if (m_readM) begin
          fl = (mode == 2) && !seen;
          if (!seen && abandon != 0) drop = 1'b1;
          seen = 1'b1;
        end
        if (cyc > 100) begin
          n_checks++;
          n_fail++;
          $display("FAIL fetch_timeout: address %0h no response after %0d cycles", a, cyc);
          done = 1'b1;
        end
      end
      @(posedge Clk);
      #1;
      c_flush = fl;
      if (drop) begin
        c_readM   = 1'b0;
        c_address = a ^ 16'h0104;
      end
    end
    c_readM = 1'b0;
    c_flush = 1'b0;
    if (abandon == 0) begin
      check("hit_latency_zero", {63'd0, cyc == 0}, {63'd0, exp_hit});
      if (!exp_hit) check("miss_latency", cyc, 3 + resp_delay);
    end
    if (exp_hit) mdl_hits++;
    else mdl_misses++;
    if (mode != 0) model_clear();
    if (!exp_hit) begin
      mv[ix] = 1'b1;
      mt[ix] = a[15:4];
    end
  endtask

  task automatic pulse_flush();
    c_flush = 1'b1;
    @(posedge Clk);
    #1;
    c_flush = 1'b0;
    model_clear();
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] a;
    logic        seen_rd;
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    mem[16'h0010] = 16'h0001;
    mem[16'h0011] = 16'h0002;
    mem[16'h0012] = 16'h0003;
    mem[16'h0013] = 16'h0004;
    model_clear();
    for (int i = 0; i < 4; i++) mt[i] = 12'd0;
    Reset     = 1'b1;
    c_readM   = 1'b0;
    c_address = 16'h0000;
    c_flush   = 1'b0;
    #2;
    check("reset_c_ready", {63'd0, c_ready}, 64'd0);
    check("reset_c_data", {48'd0, c_data}, 64'd0);
    check("reset_m_readM", {63'd0, m_readM}, 64'd0);
`ifdef ICACHE_STATS_EN
    check("reset_hit_count", {48'd0, hit_count}, 64'd0);
    check("reset_miss_count", {48'd0, miss_count}, 64'd0);
`endif
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;

    // Basic fill with 3-cycle memory, then zero-latency hit on the same block.
    resp_delay = 3;
    do_read(16'h0010, 0, 0);
    do_read(16'h0013, 0, 0);
    // Same-index replacement, then the original block misses again.
    resp_delay = 1;
    do_read(16'h0110, 0, 0);
    do_read(16'h0010, 0, 0);
    // Flush after fill.
    pulse_flush();
    do_read(16'h0010, 0, 0);
    // Flush in the same cycle as a hit: still served, then gone.
    do_read(16'h0011, 1, 0);
    do_read(16'h0011, 0, 0);
    // Flush during a miss: own line survives, others do not.
    resp_delay = 3;
    do_read(16'h0020, 2, 0);
    do_read(16'h0021, 0, 0);
    resp_delay = 0;
    do_read(16'h0010, 0, 0);
    // Abandoned request still fills its line.
    resp_delay = 2;
    do_read(16'h0030, 0, 1);
    do_read(16'h0032, 0, 0);

    // Reset while a block read is outstanding; the late m_ready must be ignored.
    resp_delay = 3;
    exp_blk    = 16'h0004;
    c_readM    = 1'b1;
    c_address  = 16'h0005;
    seen_rd    = 1'b0;
    for (int i = 0; i < 20 && !seen_rd; i++) begin
      @(negedge Clk);
      seen_rd = m_readM;
    end
    check("reset_test_miss_seen", {63'd0, seen_rd}, 64'd1);
    @(posedge Clk);
    #1;
    Reset   = 1'b1;
    c_readM = 1'b0;
    #1;
    check("midmiss_reset_m_readM", {63'd0, m_readM}, 64'd0);
    check("midmiss_reset_c_ready", {63'd0, c_ready}, 64'd0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    model_clear();
    mdl_hits   = 0;
    mdl_misses = 0;
    repeat (8) @(posedge Clk);
    #1;
    do_read(16'h0005, 0, 0);
    do_read(16'h0032, 0, 0);

    // Randomized traffic over 4 tags x 16 words to force conflicts.
    for (int n = 0; n < 200; n++) begin
      a = 16'($urandom_range(0, 3)) * 16'h0100 + 16'($urandom_range(0, 15));
      resp_delay = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) pulse_flush();
      do_read(a, ($urandom_range(0, 9) == 0) ? 1 : 0, 0);
    end

    repeat (2) @(posedge Clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
`ifdef ICACHE_STATS_EN
    check("hit_count", {48'd0, hit_count}, (mdl_hits > 65535) ? 64'hFFFF : 64'(mdl_hits));
    check("miss_count", {48'd0, miss_count}, (mdl_misses > 65535) ? 64'hFFFF : 64'(mdl_misses));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i_cache.md
I_CACHE -- requirements
Module: i_cache

Interface
REQ-001 The block SHALL have the ports below; one clock, Clk; reset, Reset, is asynchronous and active-high.
REQ-002 Clk  input  1  rising-edge clock shared with cpu.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 c_readM  input  1  cpu fetch request (cpu i_readM).
REQ-005 c_address  input  16  cpu word address (cpu i_address).
REQ-006 c_data  output  16  fetched instruction word; 16'h0000 when c_ready=0.
REQ-007 c_ready  output  1  c_data valid this cycle; cpu stalls fetch while c_readM=1 and c_ready=0.
REQ-008 c_flush  input  1  invalidate all lines.
REQ-009 m_readM  output  1  block read request to instruction memory.
REQ-010 m_address  output  16  block base address, low 2 bits 2'b00.
REQ-011 m_data  input  64  returned block, word 0 in [15:0] through word 3 in [63:48].
REQ-012 m_ready  input  1  one-cycle pulse; m_data valid that cycle.
REQ-013 Ports when ICACHE_STATS_EN defined: hit_count  output  16; miss_count  output  16.

Function
REQ-014 Organisation: direct-mapped, 4 lines x 4 words x 16 bits; tag = address[15:4], index = address[3:2], offset = address[1:0]; one valid bit per line.
REQ-015 States: IDLE, MISS, FILL.
REQ-016 IDLE, hit (c_readM=1, line valid, tag match): c_ready=1 and c_data=selected word combinationally in the same cycle; zero-cycle hit latency.
REQ-017 IDLE, miss: c_ready=0; latch c_address[15:2]; next state MISS.
REQ-018 MISS: m_readM=1, m_address={latched[15:2],2'b00}, held stable until the cycle m_ready=1; on that edge capture m_data into the line, write tag, set valid; next state FILL.
REQ-019 FILL: c_ready=1 with the word at the latched offset if c_readM=1 and c_address matches the latched block; next state IDLE.
REQ-020 m_ready outside MISS SHALL be ignored; m_readM SHALL be 0 in IDLE and FILL.
REQ-021 c_readM dropped or c_address changed during MISS: fill still completes and line becomes valid; no c_ready issued for the abandoned request.
REQ-022 c_flush in IDLE or FILL: all valid bits cleared on that edge; a hit in the same cycle is still served.
REQ-023 c_flush during MISS: valid bits cleared on that edge; in-flight fill still completes and sets its own line valid.
REQ-024 Same-index replacement overwrites the old tag and data; no write-back (read-only cache).
REQ-025 c_data SHALL be 16'h0000 whenever c_ready=0.

Reset
REQ-026 Reset=1 SHALL asynchronously force state IDLE, all valid bits 0, latched address 0, m_readM=0, c_ready=0, c_data=0, counters 0; data/tag arrays need not be cleared.
REQ-027 Reset asserted mid-MISS SHALL abandon the fill; a subsequent m_ready SHALL not write the array.

Configuration
REQ-028 Macro ICACHE_STATS_EN: when defined, hit_count increments on each cycle with an IDLE hit and miss_count on each IDLE->MISS transition, both saturating at 16'hFFFF; when undefined, the ports and counters are absent and behaviour is otherwise identical.

Verification
REQ-029 Reset, read 16'h0010 with memory returning 64'h0004_0003_0002_0001 after 3 cycles -> m_readM=1 with m_address=16'h0010, c_ready=1 c_data=16'h0001 the cycle after m_ready, and the next read of 16'h0013 hits in 0 cycles returning 16'h0004.
REQ-030 After filling 16'h0010, read 16'h0110 (same index, tag differs) -> miss, refill; a later read of 16'h0010 misses again.
REQ-031 Assert c_flush one cycle after filling 16'h0010 -> the next read of 16'h0010 misses (m_readM=1).
REQ-032 c_flush during MISS for 16'h0020 -> fill completes; a later read of 16'h0021 hits; previously valid line 16'h0010 misses.
REQ-033 Reset pulsed while in MISS, then m_ready asserted -> no c_ready, all lines invalid, the next read misses.
REQ-034 With ICACHE_STATS_EN defined, sequence miss, hit, hit, miss -> hit_count=2, miss_count=2.
